// File: rtl/alu_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_pkg
// Description : Shared mode/state encodings and the accept-time carry seed.
// Revision    : 1.0
// ============================================================================
package alu_shift_pkg;

  typedef enum logic [2:0] {
    MODE_SHL  = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_ROL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_SAR  = 3'b100,
    MODE_RCL  = 3'b101,
    MODE_RCR  = 3'b110,
    MODE_RSVD = 3'b111
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  // Carry value loaded with the operand; it is also the carry reported when cnt == 0.
  function automatic logic init_carry(input shift_mode_t m, input logic a_lsb,
                                      input logic a_msb, input logic cin);
    logic c;
    c = 1'b0;
    case (m)
      MODE_RCL, MODE_RCR: c = cin;
      MODE_ROL:           c = a_lsb;
      MODE_ROR:           c = a_msb;
      default:            c = 1'b0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_step
// Description : Combinational single-bit shift/rotate step on data and carry.
// Revision    : 1.0
// ============================================================================
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             carry_i,
  input  shift_mode_t      mode_i,
  output logic [WIDTH-1:0] d_o,
  output logic             carry_o
);

  always_comb begin
    d_o     = d_i;
    carry_o = carry_i;
    case (mode_i)
      MODE_SHR: {d_o, carry_o} = {1'b0, d_i};
      MODE_SAR: {d_o, carry_o} = {d_i[WIDTH-1], d_i};
      MODE_ROL: begin
        d_o     = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
        carry_o = d_i[WIDTH-1];
      end
      MODE_ROR: begin
        d_o     = {d_i[0], d_i[WIDTH-1:1]};
        carry_o = d_i[0];
      end
      MODE_RCL: {carry_o, d_o} = {d_i, carry_i};
      MODE_RCR: {d_o, carry_o} = {carry_i, d_i};
      // Reserved encoding shares the SHL datapath.
      default:  {carry_o, d_o} = {d_i, 1'b0};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_seq
// Description : Iterative shifter, one bit position per clock, valid/ready I/O.
// Revision    : 1.0
// ============================================================================
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [2:0]           mode,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 co,
  output logic                 zero
);

  shift_state_t         state_q;
  shift_mode_t          mode_q;
  logic [WIDTH-1:0]     data_q;
  logic                 carry_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic [WIDTH-1:0]     data_d;
  logic                 carry_d;
  shift_mode_t          mode_in;

  assign mode_in = shift_mode_t'(mode);

  alu_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .d_i     (data_q),
    .carry_i (carry_q),
    .mode_i  (mode_q),
    .d_o     (data_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SHL;
      data_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= a;
            mode_q  <= mode_in;
            carry_q <= init_carry(mode_in, a[0], a[WIDTH-1], cin);
            count_q <= cnt;
            state_q <= (cnt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_q  <= data_d;
          carry_q <= carry_d;
          count_q <= count_q - 1'b1;
          if (count_q == CNT_WIDTH'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = data_q;
  assign co        = carry_q;
  assign zero      = (data_q == '0);

endmodule
`default_nettype wire

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (SHALL be >= 2 and a power of two).
REQ-002 Parameter CNT_WIDTH, default $clog2(WIDTH), shift-count width; derived, not overridden.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 a  in  WIDTH  operand to shift.
REQ-008 cnt  in  CNT_WIDTH  shift amount, 0..WIDTH-1.
REQ-009 mode  in  3  operation: 000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 SAR, 101 RCL, 110 RCR, 111 reserved (treated as SHL).
REQ-010 cin  in  1  carry-in; used only by RCL/RCR.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out  out  WIDTH  result.
REQ-014 co  out  1  carry-out.
REQ-015 zero  out  1  high when out == 0.

Function
REQ-016 Operation SHALL be iterative: one bit-position per clock in state SHIFT.
REQ-017 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-018 IDLE, in_valid high: latch a, mode, cin, cnt; go to DONE if cnt == 0, else SHIFT with step counter = cnt.
REQ-019 SHIFT: apply one step to data/carry registers, decrement counter; go to DONE when counter reaches 0.
REQ-020 DONE: out/co/zero held stable; out_ready high -> IDLE; out_ready low -> stay in DONE (no data change).
REQ-021 Latency: out_valid SHALL assert exactly cnt+1 cycles after the accepting edge; throughput one request per cnt+2 cycles with out_ready held high.
REQ-022 A new request SHALL NOT be accepted in SHIFT or DONE; in_valid in those states is ignored.
REQ-023 SHL step: {co,d} <= {d,1'b0}; SHR step: {d,co} <= {1'b0,d}; SAR step: {d,co} <= {d[WIDTH-1],d}.
REQ-024 ROL step: d <= {d[WIDTH-2:0],d[WIDTH-1]}, co <= new d[0]; ROR step: d <= {d[0],d[WIDTH-1:1]}, co <= new d[WIDTH-1].
REQ-025 RCL step: {co,d} <= {d,co}; RCR step: {d,co} <= {co,d} (WIDTH+1-bit rotation through carry).
REQ-026 Initial carry register on accept: cin for RCL/RCR; a[0] for ROL; a[WIDTH-1] for ROR; 0 otherwise.
REQ-027 cnt == 0 SHALL return out = a with co per REQ-026.
REQ-028 mode 111 SHALL behave identically to SHL.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, out = 0, co = 0, step counter = 0, out_valid = 0, in_ready = 1 after release.
REQ-030 Reset asserted during SHIFT or DONE SHALL abort the operation; no result is emitted after release.
REQ-031 zero SHALL read 1 during and after reset (out == 0).

Structure
REQ-032 Package alu_shift_pkg SHALL hold enum shift_mode_t (mode encodings) and enum shift_state_t (IDLE, SHIFT, DONE).
REQ-033 One combinational sub-module alu_shift_step (inputs d, carry, mode; outputs next d, next carry) SHALL implement REQ-023..025; the FSM and registers live in alu_shift_seq.

Verification (WIDTH = 8)
REQ-034 SHL a=0x81 cnt=1 -> out=0x02 co=1, out_valid 2 cycles after accept; SHR a=0x01 cnt=1 -> out=0x00 co=1 zero=1.
REQ-035 ROL a=0x81 cnt=3 -> out=0x0C co=0; ROR a=0x81 cnt=1 -> out=0xC0 co=1.
REQ-036 SAR a=0x80 cnt=7 -> out=0xFF co=0; RCL a=0x80 cin=0 cnt=1 -> out=0x00 co=1; RCR a=0x01 cin=1 cnt=1 -> out=0x80 co=1.
REQ-037 SHL a=0x55 cnt=0 -> out=0x55 co=0, out_valid 1 cycle after accept; RCL a=0x55 cin=1 cnt=0 -> co=1.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out/co/out_valid stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-039 Assert rst_n=0 mid-SHIFT of SHL a=0xFF cnt=7 -> out=0, co=0, out_valid=0 immediately; after release in_ready=1 and no stale result appears.
